// File: rtl/ook_tone_pkg.sv
// ook_tone_pkg: shared state encoding and frame constants for the OOK tone transmitter
package ook_tone_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int NUM_DATA_BITS = 8;
  localparam int FRAME_BITS = 10;
  localparam logic START_KEY = 1'b1;
  localparam logic STOP_KEY = 1'b0;
endpackage

// File: rtl/tone_nco.sv
// tone_nco: phase-accumulator square-wave generator, cleared while unkeyed
module tone_nco #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clr,
  input  logic [ACC_W-1:0] tune,
  output logic             tone
);
  logic [ACC_W-1:0] acc;
  // tone lags acc by one register so the first keyed cycle shows phase 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      tone <= 1'b0;
    end else if (ena) begin
      acc <= clr ? '0 : acc + tune;
      tone <= clr ? 1'b0 : acc[ACC_W-1];
    end
endmodule

// File: rtl/ook_tone_tx.sv
// ook_tone_tx: serialises a byte as a START/8 data/STOP frame of tone bursts or silence
module ook_tone_tx
  import ook_tone_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int BIT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [ACC_W-1:0] tune_word,
  input  logic [BIT_W-1:0] bit_len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             busy,
  output logic             done,
  output logic             keyed,
  output logic             tone_out
);
  state_t state;
  logic [BIT_W-1:0] cnt, len_q;
  logic [ACC_W-1:0] tune_q;
  logic [2:0] idx;
  logic [7:0] sh;
  logic accept, bit_end, key_nxt;
  assign tx_ready = ena && state == IDLE;
  assign accept = tx_ready && tx_valid;
  assign busy = state != IDLE;
  assign bit_end = cnt == '0;
  // key level of the cycle after this edge; also drives the NCO clear
  always_comb
    key_nxt = state == IDLE ? accept && START_KEY :
              !bit_end ? keyed :
              state == START ? sh[0] :
              state == DATA ? (idx == 3'(NUM_DATA_BITS - 1) ? STOP_KEY : sh[1]) :
              1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      len_q <= '0;
      tune_q <= '0;
      idx <= '0;
      sh <= '0;
      keyed <= 1'b0;
      done <= 1'b0;
    end else if (ena) begin
      keyed <= key_nxt;
      done <= 1'b0;
      if (state == IDLE) begin
        if (tx_valid) begin
          state <= START;
          len_q <= bit_len == '0 ? BIT_W'(1) : bit_len;
          cnt <= bit_len == '0 ? '0 : bit_len - 1'b1;
          sh <= tx_data;
          tune_q <= tune_word;
        end
      end else if (!bit_end) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt <= len_q - 1'b1;
        if (state == START) begin
          state <= DATA;
          idx <= '0;
        end else if (state == DATA) begin
          sh <= sh >> 1;
          idx <= idx + 1'b1;
          if (idx == 3'(NUM_DATA_BITS - 1)) state <= STOP;
        end else begin
          state <= IDLE;
          done <= 1'b1;
        end
      end
    end
  tone_nco #(.ACC_W(ACC_W)) u_nco (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .clr  (!key_nxt),
    .tune (accept ? tune_word : tune_q),
    .tone (tone_out)
  );
endmodule

// File: tb/tb_ook_tone_tx.sv
// tb_ook_tone_tx: scoreboard bench; frames are modelled cycle by cycle at acceptance
module tb_ook_tone_tx;
  import ook_tone_pkg::*;
  localparam int ACC_W = 16;
  localparam int BIT_W = 16;
  logic clk = 1'b0, rst_n = 1'b1, ena = 1'b1, tx_valid = 1'b0;
  logic [ACC_W-1:0] tune_word = '0;
  logic [BIT_W-1:0] bit_len = '0;
  logic [7:0] tx_data = '0;
  logic tx_ready, busy, done, keyed, tone_out;
  typedef struct packed {logic busy, keyed, tone, done;} exp_t;
  exp_t q[$];
  exp_t last = '0, e;
  logic en_edge = 1'b0;
  int acc_cnt = 0, n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  ook_tone_tx #(.ACC_W(ACC_W), .BIT_W(BIT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tune_word(tune_word), .bit_len(bit_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .done(done), .keyed(keyed), .tone_out(tone_out)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic push_frame(input logic [7:0] d, input logic [ACC_W-1:0] t, input logic [BIT_W-1:0] bl);
    int l;
    logic [ACC_W-1:0] ph;
    logic k;
    l = bl == '0 ? 1 : int'(bl);
    ph = '0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      k = i == 0 ? 1'b1 : i == FRAME_BITS - 1 ? 1'b0 : d[i-1];
      for (int c = 0; c < l; c++) begin
        if (k) begin
          q.push_back('{1'b1, 1'b1, ph[ACC_W-1], 1'b0});
          ph = ph + t;
        end else begin
          q.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
          ph = '0;
        end
      end
    end
    q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
  endtask
  always @(posedge clk) begin
    en_edge = ena && rst_n;
    if (en_edge && tx_valid && q.size() == 0) begin
      push_frame(tx_data, tune_word, bit_len);
      acc_cnt++;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      last = '0;
    end else if (en_edge) last = q.size() != 0 ? q.pop_front() : '0;
    e = last;
    chk("busy", busy, e.busy);
    chk("keyed", keyed, e.keyed);
    chk("tone_out", tone_out, e.tone);
    chk("done", done, e.done);
    if (rst_n) chk("tx_ready", tx_ready, ena && q.size() == 0);
  end
  task automatic wait_accept(input int a0);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      #1 ok = acc_cnt != a0;
    end
    chk("accept", ok, 1);
  endtask
  task automatic send(input logic [7:0] d, input logic [ACC_W-1:0] t, input logic [BIT_W-1:0] bl);
    tx_data = d;
    tune_word = t;
    bit_len = bl;
    tx_valid = 1'b1;
    wait_accept(acc_cnt);
    tx_valid = 1'b0;
    tx_data = d ^ 8'hC3;
    tune_word = ~t;
    bit_len = bl + 3;
  endtask
  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk);
      #1 ok = q.size() == 0;
    end
    chk("idle", ok, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(8'hA5, 16'h4000, 16'd8);
    wait_idle();
    send(8'h03, 16'h2000, 16'd4);
    wait_idle();
    send(8'h5A, 16'h4000, 16'd0);
    wait_idle();
    send(8'h96, 16'h0000, 16'd3);
    wait_idle();
    send(8'hFF, 16'hFFFF, 16'd5);
    wait_idle();
    tx_data = 8'h00;
    tune_word = 16'h4000;
    bit_len = 16'd2;
    tx_valid = 1'b1;
    wait_accept(acc_cnt);
    tx_data = 8'hFF;
    wait_accept(acc_cnt);
    tx_valid = 1'b0;
    tx_data = 8'h00;
    wait_idle();
    send(8'h33, 16'h3000, 16'd6);
    repeat (20) @(posedge clk);
    #1 ena = 1'b0;
    repeat (5) @(posedge clk);
    #1 ena = 1'b1;
    wait_idle();
    send(8'h0F, 16'h4000, 16'd4);
    repeat (18) @(posedge clk);
    #1 chk("pre_rst_keyed", keyed, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_keyed", keyed, 0);
    chk("rst_tone", tone_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(8'hA5, 16'h4000, 16'd8);
    wait_idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
